// File: rtl/operand_sequencer_ctrl.sv
// operand_sequencer_ctrl: debounced slice-wise operand loader with add/sub and sliced result display
module operand_sequencer_ctrl #(
    parameter int DATA_W  = 32,
    parameter int IN_W    = 8,
    parameter int DEB_CYC = 4,
    localparam int SLICES = DATA_W / IN_W,
    localparam int SEL_W  = $clog2(SLICES),
    localparam int PTR_W  = $clog2(2 * SLICES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   inp,
    input  logic              set,
    input  logic              clr,
    input  logic              mode,
    input  logic              cin,
    input  logic [SEL_W-1:0]  select,
    output logic [IN_W-1:0]   out,
    output logic              cout,
    output logic [PTR_W-1:0]  slot_idx,
    output logic              result_valid,
    output logic              setled
);
    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(2 * SLICES - 1);

    typedef enum logic [1:0] {LOAD, CALC, SHOW} state_t;

    state_t              state_q, state_d;
    logic                s1, s2, press, cout_q;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] ops;
    logic [DATA_W-1:0]   a, b, result;
    logic [DATA_W:0]     sum;

    assign a     = ops[DATA_W-1:0];
    assign b     = ops[2*DATA_W-1:DATA_W];
    assign press = (cnt == CNT_W'(DEB_CYC)) && !setled;

    // Synchronise set and accept a level change only after DEB_CYC stable cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            setled <= 1'b0;
        end else begin
            s1 <= set;
            s2 <= s1;
            if (cnt == CNT_W'(DEB_CYC)) begin
                cnt    <= '0;
                setled <= ~setled;
            end else begin
                cnt <= (s2 != setled) ? cnt + 1'b1 : '0;
            end
        end
    end

    // Next state; clr overrides everything, including a coincident press
    always_comb begin
        state_d = clr                                         ? LOAD :
                  (state_q == LOAD && press && slot_idx == LAST) ? CALC :
                  (state_q == CALC)                           ? SHOW :
                  (state_q == SHOW && press)                  ? LOAD : state_q;
    end

    // Subtraction is A + ~B + 1 so cout=1 means no borrow
    always_comb begin
        sum = mode ? {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1)
                   : {1'b0, a} + {1'b0, b} + (DATA_W+1)'(cin);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // Operand loading, result capture and valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ops          <= '0;
            slot_idx     <= '0;
            result       <= '0;
            cout_q       <= 1'b0;
            result_valid <= 1'b0;
        end else if (clr) begin
            ops          <= '0;
            slot_idx     <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state_q)
                LOAD: if (press) begin
                    ops[slot_idx*IN_W +: IN_W] <= inp;
                    slot_idx <= (slot_idx == LAST) ? '0 : slot_idx + 1'b1;
                end
                CALC: begin
                    {cout_q, result} <= sum;
                    result_valid     <= 1'b1;
                end
                SHOW: if (press) begin
                    ops[IN_W-1:0] <= inp;
                    slot_idx      <= PTR_W'(1);
                    result_valid  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out  = (result_valid && int'(select) < SLICES) ? result[select*IN_W +: IN_W] : '0;
    assign cout = result_valid & cout_q;
endmodule

// File: tb/tb_operand_sequencer_ctrl.sv
// tb_operand_sequencer_ctrl: directed checks of loading, debounce, arithmetic, clr and rst
module tb_operand_sequencer_ctrl;
    logic       clk = 1'b0, rst = 1'b1, set = 1'b0, clr = 1'b0, mode = 1'b0, cin = 1'b0;
    logic [7:0] inp = '0, out;
    logic [1:0] select = '0;
    logic [2:0] slot_idx;
    logic       cout, result_valid, setled;
    int         checks = 0, errors = 0;

    operand_sequencer_ctrl dut (
        .clk(clk), .rst(rst), .inp(inp), .set(set), .clr(clr), .mode(mode), .cin(cin),
        .select(select), .out(out), .cout(cout), .slot_idx(slot_idx),
        .result_valid(result_valid), .setled(setled)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_setled(output int lat);
        lat = 0;
        while (!setled && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 30) check("press_timeout", 64'(setled), 64'd1);
    endtask

    task automatic release_set();
        repeat (6) @(negedge clk);
        set = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] v);
        int lat;
        inp = v;
        set = 1'b1;
        wait_setled(lat);
        release_set();
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) press(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) press(b[8*i +: 8]);
    endtask

    task automatic check_res(input string tag, input logic [31:0] r, input logic c);
        check({tag, "_valid"}, 64'(result_valid), 64'd1);
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            #1;
            check($sformatf("%s_out%0d", tag, s), 64'(out), 64'(r[8*s +: 8]));
        end
        check({tag, "_cout"}, 64'(cout), 64'(c));
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out", 64'(out), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_slot", 64'(slot_idx), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_setled", 64'(setled), 64'd0);

        // 1: FFFFFFFF + 1, with press and valid latency checked on the final slice
        for (int i = 0; i < 4; i++) press(8'hFF);
        press(8'h01); press(8'h00); press(8'h00);
        inp = 8'h00;
        set = 1'b1;
        wait_setled(lat);
        check("press_latency", 64'(lat), 64'd7);
        check("calc_not_valid", 64'(result_valid), 64'd0);
        check("slot_wrap", 64'(slot_idx), 64'd0);
        @(negedge clk);
        check("valid_latency", 64'(result_valid), 64'd1);
        release_set();
        check_res("add_wrap", 32'h0000_0000, 1'b1);

        // 2: subtraction with and without borrow
        mode = 1'b1;
        load(32'h5, 32'h7);
        check_res("sub_borrow", 32'hFFFF_FFFE, 1'b0);
        load(32'h5, 32'h5);
        check_res("sub_zero", 32'h0, 1'b1);
        mode = 1'b0;

        // 3: bounce gives no press; clean long hold gives exactly one
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_show_valid", 64'(result_valid), 64'd0);
        check("clr_show_cout", 64'(cout), 64'd0);
        inp = 8'h3C;
        set = 1'b1; repeat (2) @(negedge clk);
        set = 1'b0; repeat (3) @(negedge clk);
        set = 1'b1; @(negedge clk);
        set = 1'b0; repeat (15) @(negedge clk);
        check("bounce_slot", 64'(slot_idx), 64'd0);
        check("bounce_setled", 64'(setled), 64'd0);
        check("bounce_ops", dut.ops, 64'd0);
        set = 1'b1; repeat (50) @(negedge clk);
        set = 1'b0; repeat (12) @(negedge clk);
        check("hold_slot", 64'(slot_idx), 64'd1);
        check("hold_ops", dut.ops, 64'h3C);

        // 4: clr after five loads, then clr colliding with a press
        for (int i = 0; i < 4; i++) press(8'h11 * 8'(i + 1));
        check("five_slot", 64'(slot_idx), 64'd5);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_slot", 64'(slot_idx), 64'd0);
        check("clr_ops", dut.ops, 64'd0);
        inp = 8'h77;
        set = 1'b1;
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_press_setled", 64'(setled), 64'd1);
        check("clr_press_slot", 64'(slot_idx), 64'd0);
        check("clr_press_ops", dut.ops, 64'd0);
        release_set();

        // 5: reset in SHOW, then 0 + 0 + cin
        load(32'h1, 32'h2);
        check_res("pre_rst", 32'h3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        select = 2'd0;
        #1;
        check("rst_show_out", 64'(out), 64'd0);
        check("rst_show_valid", 64'(result_valid), 64'd0);
        check("rst_show_slot", 64'(slot_idx), 64'd0);
        check("rst_show_ops", dut.ops, 64'd0);
        cin = 1'b1;
        load(32'h0, 32'h0);
        check_res("cin_only", 32'h1, 1'b0);
        cin = 1'b0;

        // 6: press in SHOW restarts loading at A slice 0 and keeps other slices
        load(32'h1122_3344, 32'h5566_7788);
        check_res("add_mix", 32'h6688_AACC, 1'b0);
        press(8'hAA);
        select = 2'd0;
        #1;
        check("show_press_valid", 64'(result_valid), 64'd0);
        check("show_press_out", 64'(out), 64'd0);
        check("show_press_slot", 64'(slot_idx), 64'd1);
        check("show_press_ops", dut.ops, 64'h5566_7788_1122_33AA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
